ext_uart_rx: RTL
================

Name: ext_uart_rx

Overview:
Multi-lane mini-frame UART receiver. It is the receive end of the ExtUART link: it accepts the W_BUS-wide line driven by the ExtUART transmitter and reassembles N_SEG segments into one W_DAT-bit word. It sits directly behind the board input pins and presents the word plus one-cycle receive and error flags to the fabric. Line format per segment: 1 start mini-frame (all lanes 0), N_DMF data mini-frames (least significant W_BUS bits first), N_SMF stop mini-frames (all lanes 1). Segments are sent most significant first; idle line is all 1s.

Parameters:
N_SEG, 2, number of segments per transaction
N_DMF, 4, data mini-frames per segment
N_SMF, 1, stop mini-frames per segment (min 1)
W_BUS, 4, width of RxD bus
W_BAU, 8, width of baud counter
Derived: W_DAT = N_DMF*W_BUS*N_SEG; WD = N_DMF*W_BUS

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
baud  in  W_BAU  clock cycles per mini-frame (min 4); sampled at start detection, held per segment
exu_rxd  in  W_BUS  RxD bus, asynchronous to clk
dat  out  W_DAT  last correctly received word
f_rcv  out  1  receive-done flag, one-cycle positive pulse
f_err  out  1  framing/timeout error flag, one-cycle positive pulse

Behaviour:
- Reset (async, active-high): dat=0, f_rcv=0, f_err=0, sync regs all 1s, state=IDLE, all counters 0. Reset mid-transaction discards the partial word; dat keeps no partial data.
- Input: 2-flop synchronizer per lane, reset to 1s; all decisions use the synchronized value rxs. This adds 2 cycles of latency.
- Baud counter ctr_bau: loaded with baud>>1 on start detection, then reloaded with baud at each sample tick. A tick fires when ctr_bau reaches 1.
- States:
  - IDLE: wait for rxs == 0 (all lanes low). Then load baud, seg=0, and go to START. Partial-low patterns are ignored.
  - START: at the half-period tick, check that rxs == 0. If true, go to DATA with frm=0. If not, treat it as a glitch: return to IDLE with no error.
  - DATA: at each tick, shift rxs into the segment shift register at the top, so the first mini-frame ends up in bits [W_BUS-1:0]. After N_DMF samples go to STOP.
  - STOP: at each tick, require rxs == all 1s. Any other value: pulse f_err, discard, go to IDLE. After N_SMF good stops, store the segment into slot dat_sh[WD*(N_SEG-seg)-1 : WD*(N_SEG-seg-1)].
    - If seg == N_SEG-1: dat <= assembled word and f_rcv pulses in the same cycle, then go to IDLE.
    - Otherwise: seg++ and go to GAP.
  - GAP: wait for rxs == 0 and then go to START as from IDLE. If 4*baud cycles elapse with no start, pulse f_err and go to IDLE (timeout counter W_BAU+2 bits).
- Latency: dat valid and f_rcv high 1 cycle after the last stop-sample tick.
- f_rcv and f_err never assert in the same cycle. Each is exactly one cycle wide.
- The assembled word is updated only on full success; dat is stable otherwise.
- Back-to-back transactions: a start in the cycle right after f_rcv must be detected, because IDLE is entered on that same edge.
- baud is captured into an internal register at IDLE->START. A baud change mid-transaction has no effect until the next transaction.

Test Plan:
- Defaults, baud=8, line F,0,4,3,2,1,F,0,D,C,B,A,F with each mini-frame held 8 cycles -> dat=0x1234ABCD, one f_rcv pulse, f_err stays 0.
- Same frame, but the first stop mini-frame is 0x7 -> f_err single pulse, no f_rcv, dat keeps its previous value (0 after reset).
- Low glitch 0x0 for 2 cycles on an idle line, baud=8 -> no f_rcv, no f_err, state back to IDLE; a valid frame right after is received correctly.
- First segment sent, then line held at F for 40 cycles, baud=8 -> f_err pulses at 32 cycles (±3) after the GAP entry.
- rst asserted mid-DATA of the second segment, then a full frame 0xCAFEF00D -> dat=0xCAFEF00D, single f_rcv, no stale nibbles.
- Two back-to-back frames 0x00000001 and 0xFFFFFFFF with no idle gap, baud=4 -> two f_rcv pulses, dat showing each value in order.

Source files
------------

// File: rtl/ext_uart_rx.sv
// ext_uart_rx: multi-lane mini-frame UART receiver that reassembles N_SEG segments into one word.
// Segments arrive most significant first; each segment is start, N_DMF data and N_SMF stop mini-frames.
module ext_uart_rx #(
    parameter int N_SEG = 2,
    parameter int N_DMF = 4,
    parameter int N_SMF = 1,
    parameter int W_BUS = 4,
    parameter int W_BAU = 8,
    localparam int W_DAT = N_DMF * W_BUS * N_SEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W_BAU-1:0] baud,
    input  logic [W_BUS-1:0] exu_rxd,
    output logic [W_DAT-1:0] dat,
    output logic             f_rcv,
    output logic             f_err
);
    localparam int WD = N_DMF * W_BUS;
    localparam int W_FRM = $clog2(N_DMF + N_SMF + 1);
    localparam int W_SEG = $clog2(N_SEG + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

    state_t             state, state_nxt;
    logic [W_BUS-1:0]   s1, rxs;
    logic [W_BAU-1:0]   ctr_bau, baud_r;
    logic [W_BAU+1:0]   tmo, tmo_max;
    logic [W_FRM-1:0]   frm;
    logic [W_SEG-1:0]   seg;
    logic [WD-1:0]      sh;
    logic [W_DAT-1:0]   dat_sh, word;
    logic               rx_low, rx_high, tick, frm_dl, frm_sl, seg_last, tmo_end;
    logic               seg_done, rcv_nxt, err_nxt;

    assign rx_low   = rxs == '0;
    assign rx_high  = &rxs;
    assign tick     = ctr_bau == W_BAU'(1);
    assign frm_dl   = frm == W_FRM'(N_DMF - 1);
    assign frm_sl   = frm == W_FRM'(N_DMF + N_SMF - 1);
    assign seg_last = seg == W_SEG'(N_SEG - 1);
    assign tmo_max  = {baud_r, 2'b00} - 1'b1;
    assign tmo_end  = tmo == tmo_max;

    always_comb begin
        word = dat_sh;
        word[WD*(N_SEG-1-int'(seg)) +: WD] = sh;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = rx_low ? START : IDLE;
            START:   state_nxt = !tick ? START : (rx_low ? DATA : IDLE);
            DATA:    state_nxt = (tick && frm_dl) ? STOP : DATA;
            STOP:    state_nxt = !tick || (rx_high && !frm_sl) ? STOP :
                                 (rx_high && !seg_last) ? GAP : IDLE;
            GAP:     state_nxt = rx_low ? START : (tmo_end ? IDLE : GAP);
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        seg_done = state == STOP && tick && rx_high && frm_sl;
        rcv_nxt  = seg_done && seg_last;
        err_nxt  = (state == STOP && tick && !rx_high) || (state == GAP && !rx_low && tmo_end);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1      <= '1;
            rxs     <= '1;
            ctr_bau <= '0;
            baud_r  <= '0;
            tmo     <= '0;
            frm     <= '0;
            seg     <= '0;
            sh      <= '0;
            dat_sh  <= '0;
            dat     <= '0;
            f_rcv   <= 1'b0;
            f_err   <= 1'b0;
        end else begin
            s1    <= exu_rxd;
            rxs   <= s1;
            f_rcv <= rcv_nxt;
            f_err <= err_nxt;
            tmo   <= state == GAP ? tmo + 1'b1 : '0;
            // a new transaction captures baud; later segments keep the captured rate
            if (state == IDLE && rx_low) begin
                baud_r  <= baud;
                ctr_bau <= baud >> 1;
                seg     <= '0;
            end else if (state == GAP && rx_low)
                ctr_bau <= baud_r >> 1;
            else if (state inside {START, DATA, STOP})
                ctr_bau <= tick ? baud_r : ctr_bau - 1'b1;
            else
                ctr_bau <= '0;
            if (tick && state == START)
                frm <= '0;
            else if (tick && (state == DATA || state == STOP))
                frm <= frm + 1'b1;
            if (tick && state == DATA)
                sh <= {rxs, sh[WD-1:W_BUS]};
            if (seg_done) begin
                dat_sh <= word;
                seg    <= seg + 1'b1;
            end
            if (rcv_nxt)
                dat <= word;
        end
    end
endmodule
